fifo16_synth: RTL and testbench

FIFO16_SYNTH -- requirements
Module: fifo16_synth

---
 rtl/fifo16_if.sv | 27 ++
 rtl/fifo16_synth.sv | 52 +++++
 tb/tb_fifo16_synth.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fifo16_if.sv
// fifo16_if: write/read handshake, thresholds and status bundle for fifo16_synth
interface fifo16_if #(
    parameter int BUF_WIDTH  = 4,
    parameter int DATA_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] buf_in;
    logic [DATA_WIDTH-1:0] uH;
    logic [DATA_WIDTH-1:0] uL;
    logic [DATA_WIDTH-1:0] buf_out;
    logic                  wr_en;
    logic                  rd_en;
    logic                  buf_empty;
    logic                  buf_full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [BUF_WIDTH:0]    fifo_counter;

    modport master (
        output buf_in, wr_en, rd_en, uH, uL,
        input  buf_out, buf_empty, buf_full, almost_empty, almost_full, fifo_counter
    );

    modport slave (
        input  buf_in, wr_en, rd_en, uH, uL,
        output buf_out, buf_empty, buf_full, almost_empty, almost_full, fifo_counter
    );
endinterface

// File: rtl/fifo16_synth.sv
// fifo16_synth: synchronous FIFO with occupancy counter and programmable watermarks
module fifo16_synth #(
    parameter int BUF_WIDTH  = 4,
    parameter int DATA_WIDTH = 4
) (
    input logic     clk,
    input logic     rst,
    fifo16_if.slave bus
);
    localparam int DEPTH = 1 << BUF_WIDTH;
    localparam logic [BUF_WIDTH:0] DEPTH_W = (BUF_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [BUF_WIDTH-1:0]  wr_ptr;
    logic [BUF_WIDTH-1:0]  rd_ptr;
    logic [BUF_WIDTH:0]    count;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = bus.wr_en & ~bus.buf_full;
    assign rd_ok = bus.rd_en & ~bus.buf_empty;

    assign bus.fifo_counter = count;
    assign bus.buf_empty    = count == '0;
    assign bus.buf_full     = count == DEPTH_W;
    assign bus.almost_full  = count >= DEPTH_W - (BUF_WIDTH+1)'(bus.uH);
    assign bus.almost_empty = count <= (BUF_WIDTH+1)'(bus.uL);

    // storage is not reset; only pointers and counter define validity
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.buf_in;
    end

    // pointers wrap naturally at DEPTH; counter tracks net occupancy change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (wr_ok & ~rd_ok) ? count + 1'b1 : (rd_ok & ~wr_ok) ? count - 1'b1 : count;
        end
    end

    // registered read data, held when no read is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.buf_out <= '0;
        else if (rd_ok) bus.buf_out <= mem[rd_ptr];
    end
endmodule

// File: tb/tb_fifo16_synth.sv
// tb_fifo16_synth: directed scoreboard bench for fifo16_synth (uH=2, uL=3)
module tb_fifo16_synth;
    typedef struct {
        int cnt;
        int out;
        bit e;
        bit f;
        bit ae;
        bit af;
    } exp_t;

    logic clk = 0;
    logic rst = 1;
    int total = 0;
    int bad = 0;
    int n = 0;
    exp_t q[$];

    fifo16_if #(.BUF_WIDTH(4), .DATA_WIDTH(4)) bus ();

    fifo16_synth #(.BUF_WIDTH(4), .DATA_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input int c, input int o);
        exp_t r;
        r.cnt = c;
        r.out = o;
        r.e   = (c == 0);
        r.f   = (c == 16);
        r.ae  = (c <= 3);
        r.af  = (c >= 14);
        return r;
    endfunction

    task automatic cmp(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    task automatic check_all(input string tag, input exp_t x);
        cmp({tag, ".count"}, int'(bus.fifo_counter), x.cnt);
        cmp({tag, ".buf_out"}, int'(bus.buf_out), x.out);
        cmp({tag, ".empty"}, int'(bus.buf_empty), int'(x.e));
        cmp({tag, ".full"}, int'(bus.buf_full), int'(x.f));
        cmp({tag, ".almost_empty"}, int'(bus.almost_empty), int'(x.ae));
        cmp({tag, ".almost_full"}, int'(bus.almost_full), int'(x.af));
    endtask

    task automatic step(input bit w, input int d, input bit r, input int ec, input int eo);
        @(negedge clk);
        bus.wr_en  = w;
        bus.buf_in = 4'(d);
        bus.rd_en  = r;
        q.push_back(mk(ec, eo));
    endtask

    // monitor: after each edge compare the DUT against the oldest pending expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                check_all($sformatf("step%0d", n), x);
                n++;
            end
        end
    end

    initial begin
        bus.wr_en  = 0;
        bus.rd_en  = 0;
        bus.buf_in = 0;
        bus.uH     = 4'd2;
        bus.uL     = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", mk(0, 0));
        @(negedge clk);
        rst = 0;
        step(1, 1, 0, 1, 0);
        step(1, 2, 1, 1, 1);
        step(0, 0, 1, 0, 2);
        step(1, 10, 1, 1, 2);
        step(0, 0, 1, 0, 10);
        for (int i = 0; i < 16; i++) step(1, (i + 3) % 16, 0, i + 1, 10);
        step(1, 9, 0, 16, 10);
        step(1, 5, 1, 15, 3);
        for (int k = 1; k < 16; k++) step(0, 0, 1, 15 - k, (k + 3) % 16);
        step(0, 0, 1, 0, 2);
        for (int i = 0; i < 11; i++) step(1, i + 1, 0, i + 1, 2);
        step(0, 0, 1, 10, 1);
        @(negedge clk);
        bus.wr_en  = 1;
        bus.buf_in = 4'd4;
        bus.rd_en  = 0;
        #2;
        rst = 1;
        #1;
        check_all("async_rst", mk(0, 0));
        @(posedge clk);
        #1;
        check_all("rst_hold", mk(0, 0));
        @(negedge clk);
        rst = 0;
        bus.wr_en = 0;
        step(1, 7, 0, 1, 0);
        step(0, 0, 1, 0, 7);
        @(negedge clk);
        bus.wr_en = 0;
        bus.rd_en = 0;
        repeat (2) @(posedge clk);
        #2;
        cmp("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
